// File: rtl/ldpc_layer_update.sv
// ldpc_layer_update: one layer of a layered LDPC decoder's variable-node side.
//   Front half : Q = P - R per edge (clamped), registered to o_q_* with
//                o_ms_latch, and stored in a circular Q buffer.
//   Back half  : when the matching min-sign result (i_rnew_*) arrives
//                MS_LATENCY cycles after o_ms_latch, pop Q and emit
//                P_new = Q + Rnew (clamped) on o_p_*, plus o_r_* = i_rnew_*.
// Ports:
//   i_clock, i_reset (async, active-high), i_flush (sync clear)
//   i_valid, i_p_a0..5, i_r_a0..5      : one check row in
//   o_q_a0..5, o_ms_latch              : to the min-sign stage
//   i_rnew_a0..5                       : from the min-sign stage
//   o_p_a0..5, o_r_a0..5, o_valid      : updated posteriors / messages
//   o_row_index, o_layer_done          : row position within the layer
//   o_sat_count, o_overflow            : clamp counter, sticky buffer error

// Per-edge arithmetic: both 9-bit sums clamped to the symmetric range.
module ldpc_edge (
  input  logic signed [7:0] p, r, qb, rnew,
  output logic signed [7:0] q, pn,
  output logic              q_sat, pn_sat
);
  logic signed [8:0] d, s;
  assign d = {p[7], p} - {r[7], r};
  assign s = {qb[7], qb} + {rnew[7], rnew};

  always_comb begin
    q = d[7:0];
    q_sat = 1'b0;
    if (d > 9'sd127) begin
      q = 8'sd127;
      q_sat = 1'b1;
    end else if (d < -9'sd127) begin
      q = -8'sd127;
      q_sat = 1'b1;
    end
  end

  always_comb begin
    pn = s[7:0];
    pn_sat = 1'b0;
    if (s > 9'sd127) begin
      pn = 8'sd127;
      pn_sat = 1'b1;
    end else if (s < -9'sd127) begin
      pn = -8'sd127;
      pn_sat = 1'b1;
    end
  end
endmodule

module ldpc_layer_update #(
  parameter int MS_LATENCY     = 5,
  parameter int QDEPTH         = 8,
  parameter int ROWS_PER_LAYER = 16,
  localparam int RW = (ROWS_PER_LAYER > 1) ? $clog2(ROWS_PER_LAYER) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [7:0]    i_p_a0, i_p_a1, i_p_a2, i_p_a3, i_p_a4, i_p_a5,
  input  logic [7:0]    i_r_a0, i_r_a1, i_r_a2, i_r_a3, i_r_a4, i_r_a5,
  output logic [7:0]    o_q_a0, o_q_a1, o_q_a2, o_q_a3, o_q_a4, o_q_a5,
  output logic          o_ms_latch,
  input  logic [7:0]    i_rnew_a0, i_rnew_a1, i_rnew_a2, i_rnew_a3, i_rnew_a4, i_rnew_a5,
  output logic [7:0]    o_p_a0, o_p_a1, o_p_a2, o_p_a3, o_p_a4, o_p_a5,
  output logic [7:0]    o_r_a0, o_r_a1, o_r_a2, o_r_a3, o_r_a4, o_r_a5,
  output logic          o_valid,
  output logic [RW-1:0] o_row_index,
  output logic          o_layer_done,
  output logic [15:0]   o_sat_count,
  output logic          o_overflow
);
  localparam int LANES = 6;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW = $clog2(QDEPTH + 1);

  logic [LANES-1:0][7:0] p, r, rnew, q, pn, qb, q_reg, p_reg, r_reg;
  logic [LANES-1:0]      q_sat, pn_sat;
  logic [LANES-1:0][7:0] qmem [QDEPTH];
  logic [MS_LATENCY:0]   vld_pipe;   // bit k high in cycle k+1 after acceptance
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         occ;
  logic [RW-1:0]         row_cnt;
  logic                  accept, pop_req, full, empty, do_push, do_pop;
  logic [16:0]           sat_sum;

  assign p    = {i_p_a5, i_p_a4, i_p_a3, i_p_a2, i_p_a1, i_p_a0};
  assign r    = {i_r_a5, i_r_a4, i_r_a3, i_r_a2, i_r_a1, i_r_a0};
  assign rnew = {i_rnew_a5, i_rnew_a4, i_rnew_a3, i_rnew_a2, i_rnew_a1, i_rnew_a0};

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      ldpc_edge u_edge (
        .p(p[g]), .r(r[g]), .qb(qb[g]), .rnew(rnew[g]),
        .q(q[g]), .pn(pn[g]), .q_sat(q_sat[g]), .pn_sat(pn_sat[g])
      );
    end
  endgenerate

  assign accept  = i_valid & ~i_flush;
  assign pop_req = vld_pipe[MS_LATENCY];
  assign full    = (occ == OW'(QDEPTH));
  assign empty   = (occ == '0);
  assign do_pop  = pop_req & ~empty;
  // The Q entry is written on the same edge that registers o_q, so it is
  // already resident during the o_ms_latch cycle. A full buffer still
  // accepts when a pop frees a slot in the same cycle.
  assign do_push = accept & (~full | do_pop);
  // An underflowing pop yields a zero Q rather than stale buffer contents.
  assign qb      = empty ? '0 : qmem[rd_ptr];

  assign sat_sum = {1'b0, o_sat_count}
                 + 17'($countones(q_sat & {LANES{accept}}))
                 + 17'($countones(pn_sat & {LANES{pop_req}}));

  always_ff @(posedge i_clock)
    if (do_push) qmem[wr_ptr] <= q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe     <= '0;
      q_reg        <= '0;
      p_reg        <= '0;
      r_reg        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      row_cnt      <= '0;
      o_valid      <= 1'b0;
      o_row_index  <= '0;
      o_layer_done <= 1'b0;
      o_sat_count  <= '0;
      o_overflow   <= 1'b0;
    end else if (i_flush) begin
      vld_pipe     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      row_cnt      <= '0;
      o_valid      <= 1'b0;
      o_row_index  <= '0;
      o_layer_done <= 1'b0;
      o_sat_count  <= '0;
      o_overflow   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[MS_LATENCY-1:0], accept};
      if (accept) q_reg <= q;

      if (do_push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push & ~do_pop)      occ <= occ + 1'b1;
      else if (do_pop & ~do_push) occ <= occ - 1'b1;
      if (accept & ~do_push) o_overflow <= 1'b1;

      o_valid      <= pop_req;
      o_layer_done <= 1'b0;
      if (pop_req) begin
        p_reg        <= pn;
        r_reg        <= rnew;
        o_row_index  <= row_cnt;
        o_layer_done <= (row_cnt == RW'(ROWS_PER_LAYER - 1));
        row_cnt      <= (row_cnt == RW'(ROWS_PER_LAYER - 1)) ? '0 : row_cnt + 1'b1;
      end

      o_sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign o_ms_latch = vld_pipe[0];
  assign {o_q_a5, o_q_a4, o_q_a3, o_q_a2, o_q_a1, o_q_a0} = q_reg;
  assign {o_p_a5, o_p_a4, o_p_a3, o_p_a2, o_p_a1, o_p_a0} = p_reg;
  assign {o_r_a5, o_r_a4, o_r_a3, o_r_a2, o_r_a1, o_r_a0} = r_reg;
endmodule
